// File: rtl/ope_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ope_sequencer                                                |
// | Description : Decodes one instruction at a time, fires its ALU phases,     |
// |               then retires it. Execution phases freeze while mem_busy=1.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module ope_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ope_valid,
    input  logic [31:0]      ope,
    output logic             ope_ready,
    input  logic             mem_busy,
    output logic [31:0]      ope_latched,
    output logic [3:0]       num_of_ope,
    output logic             phase_a,
    output logic             phase_b,
    output logic             phase_c,
    output logic             retire,
    output logic             jump,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_count
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_DECODE = 3'd1;
    localparam logic [2:0] c_EXEC_A = 3'd2;
    localparam logic [2:0] c_EXEC_B = 3'd3;
    localparam logic [2:0] c_EXEC_C = 3'd4;
    localparam logic [2:0] c_RETIRE = 3'd5;

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [31:0]      r_ope_latched;
    logic [3:0]       r_num_of_ope;
    logic [1:0]       r_phases;
    logic             r_jump;
    logic             r_illegal;
    logic [CNT_W-1:0] r_retired_count;

    logic [3:0]       w_dec_len;
    logic [1:0]       w_dec_phases;
    logic             w_dec_jump;
    logic             w_dec_illegal;
    logic             w_ready;
    logic             w_phase_a;
    logic             w_phase_b;
    logic             w_phase_c;
    logic             w_retire;

    // Decode is combinational on the latched opcode and captured in DECODE.
    always_comb begin
        w_dec_len     = 4'd1;
        w_dec_phases  = 2'd0;
        w_dec_jump    = 1'b0;
        w_dec_illegal = 1'b0;
        case (r_ope_latched[31:24])
            8'h55:   begin w_dec_len = 4'd1; w_dec_phases = 2'd2; end
            8'h89:   begin w_dec_len = 4'd2; w_dec_phases = 2'd1; end
            8'hb8:   begin w_dec_len = 4'd5; w_dec_phases = 2'd1; end
            8'h5d:   begin w_dec_len = 4'd1; w_dec_phases = 2'd2; end
            8'hc3:   begin w_dec_len = 4'd1; w_dec_phases = 2'd2; w_dec_jump = 1'b1; end
            8'he8:   begin w_dec_len = 4'd5; w_dec_phases = 2'd3; w_dec_jump = 1'b1; end
            8'he2:   begin w_dec_len = 4'd2; w_dec_phases = 2'd3; w_dec_jump = 1'b1; end
            8'h6a:   begin w_dec_len = 4'd2; w_dec_phases = 2'd2; end
            8'h8b:   begin w_dec_len = 4'd3; w_dec_phases = 2'd2; end
            8'h83:   begin w_dec_len = 4'd3; w_dec_phases = 2'd1; end
            default: w_dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_phase_a    = 1'b0;
        w_phase_b    = 1'b0;
        w_phase_c    = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_ready = 1'b1;
                if (ope_valid) w_next_state = c_DECODE;
            end
            c_DECODE: w_next_state = (w_dec_phases == 2'd0) ? c_RETIRE : c_EXEC_A;
            c_EXEC_A: if (!mem_busy) begin
                w_phase_a    = 1'b1;
                w_next_state = (r_phases > 2'd1) ? c_EXEC_B : c_RETIRE;
            end
            c_EXEC_B: if (!mem_busy) begin
                w_phase_b    = 1'b1;
                w_next_state = (r_phases > 2'd2) ? c_EXEC_C : c_RETIRE;
            end
            c_EXEC_C: if (!mem_busy) begin
                w_phase_c    = 1'b1;
                w_next_state = c_RETIRE;
            end
            c_RETIRE: begin
                w_retire     = 1'b1;
                w_next_state = c_IDLE;
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= c_IDLE;
            r_ope_latched   <= 32'd0;
            r_num_of_ope    <= 4'd0;
            r_phases        <= 2'd0;
            r_jump          <= 1'b0;
            r_illegal       <= 1'b0;
            r_retired_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_ready && ope_valid) r_ope_latched <= ope;
            if (r_state == c_DECODE) begin
                r_num_of_ope <= w_dec_len;
                r_phases     <= w_dec_phases;
                r_jump       <= w_dec_jump;
                r_illegal    <= w_dec_illegal;
            end
            if (w_retire) r_retired_count <= r_retired_count + 1'b1;
        end
    end

    assign ope_ready     = w_ready;
    assign ope_latched   = r_ope_latched;
    assign num_of_ope    = r_num_of_ope;
    assign phase_a       = w_phase_a;
    assign phase_b       = w_phase_b;
    assign phase_c       = w_phase_c;
    assign retire        = w_retire;
    // Flags are only meaningful during the retire cycle.
    assign jump          = w_retire & r_jump;
    assign illegal       = w_retire & r_illegal;
    assign retired_count = r_retired_count;

endmodule
`default_nettype wire
